// File: rtl/sfifo_pkg.sv
// Shared constants and pointer helper for the synchronous FIFO family.
package sfifo_pkg;

    localparam int SFIFO_W     = 8;
    localparam int SFIFO_H     = 8;
    localparam int SFIFO_AE_TH = 2;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr == depth - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port register array: one write port, one registered read port.
module sfifo_ram
    import sfifo_pkg::*;
#(
    parameter  int W  = SFIFO_W,
    parameter  int H  = SFIFO_H,
    localparam int AW = $clog2(H)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic          re_i,
    input  logic [AW-1:0] ra_i,
    output logic [W-1:0]  rd_o
);

    logic [W-1:0] mem_q [H];
    logic [W-1:0] rd_q;

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Registered read: a same-edge write to the same entry returns old data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q <= {W{1'b0}};
        end else if (re_i) begin
            rd_q <= mem_q[ra_i];
        end else begin
            rd_q <= rd_q;
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/sfifo_ext.sv
// Synchronous FIFO with count, thresholds and read-valid strobe; any depth >= 2.
// Sticky overflow/underflow flags are built only when SFIFO_ERR_EN is defined.
module sfifo_ext
    import sfifo_pkg::*;
#(
    parameter int W     = SFIFO_W,
    parameter int H     = SFIFO_H,
    parameter int AF_TH = H - 2,
    parameter int AE_TH = SFIFO_AE_TH,
    parameter int CW    = $clog2(H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  wr_data,
    input  logic          r,
    output logic [W-1:0]  r_data,
    output logic          r_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int PW = $clog2(H);

    if (H < 2) begin : g_bad_depth
        $error("sfifo_ext: H must be at least 2");
    end
    if (!((AE_TH >= 0) && (AE_TH < AF_TH) && (AF_TH <= H))) begin : g_bad_thresh
        $error("sfifo_ext: thresholds must satisfy 0 <= AE_TH < AF_TH <= H");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, afull_q, aempty_q, r_valid_q;
    logic          wr_en_s, r_en_s;

    // Accept rules, next pointers and next occupancy.
    always_comb begin
        r_en_s   = r & ~empty_q;
        wr_en_s  = wr & (~full_q | r);
        wr_ptr_d = wr_ptr_q;
        r_ptr_d  = r_ptr_q;
        if (wr_en_s) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), 32'(H)));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (r_en_s) begin
            r_ptr_d = PW'(ptr_inc(32'(r_ptr_q), 32'(H)));
        end else begin
            r_ptr_d = r_ptr_q;
        end
        count_d = count_q + CW'(wr_en_s) - CW'(r_en_s);
    end

    // Pointers, count and all status flags update together from count_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {PW{1'b0}};
            r_ptr_q   <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            r_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            r_ptr_q   <= r_ptr_d;
            count_q   <= count_d;
            full_q    <= (count_d == CW'(H));
            empty_q   <= (count_d == {CW{1'b0}});
            afull_q   <= (count_d >= CW'(AF_TH));
            aempty_q  <= (count_d <= CW'(AE_TH));
            r_valid_q <= r_en_s;
        end
    end

`ifdef SFIFO_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky error capture, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (wr & ~wr_en_s);
            underflow_q <= underflow_q | (r & empty_q);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    sfifo_ram #(
        .W (W),
        .H (H)
    ) u_ram (
        .clk_i (clk),
        .rst_i (rst),
        .we_i  (wr_en_s & ~rst),
        .wa_i  (wr_ptr_q),
        .wd_i  (wr_data),
        .re_i  (r_en_s & ~rst),
        .ra_i  (r_ptr_q),
        .rd_o  (r_data)
    );

    assign r_valid      = r_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;

endmodule

// File: tb/tb_sfifo_ext.sv
// Self-checking bench for sfifo_ext: queue-based reference model, H=8 and H=5 instances.
module tb_sfifo_ext;

`ifdef SFIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // H = 8 instance
    logic       rst8 = 1'b1, wr8 = 1'b0, r8 = 1'b0;
    logic [7:0] wd8 = 8'h00, rd8;
    logic       rv8, full8, empty8, af8, ae8, ovf8, unf8;
    logic [3:0] cnt8;

    // H = 5 instance
    logic       rst5 = 1'b1, wr5 = 1'b0, r5 = 1'b0;
    logic [7:0] wd5 = 8'h00, rd5;
    logic       rv5, full5, empty5, af5, ae5, ovf5, unf5;
    logic [2:0] cnt5;

    sfifo_ext #(.W(8), .H(8), .AF_TH(6), .AE_TH(2)) u8 (
        .clk(clk), .rst(rst8), .wr(wr8), .wr_data(wd8), .r(r8), .r_data(rd8),
        .r_valid(rv8), .full(full8), .empty(empty8), .almost_full(af8),
        .almost_empty(ae8), .count(cnt8), .overflow(ovf8), .underflow(unf8));

    sfifo_ext #(.W(8), .H(5), .AF_TH(4), .AE_TH(1)) u5 (
        .clk(clk), .rst(rst5), .wr(wr5), .wr_data(wd5), .r(r5), .r_data(rd5),
        .r_valid(rv5), .full(full5), .empty(empty5), .almost_full(af5),
        .almost_empty(ae5), .count(cnt5), .overflow(ovf5), .underflow(unf5));

    // Reference model state
    logic [7:0] q8[$], q5[$];
    logic [7:0] e_rd8 = 8'h00, e_rd5 = 8'h00;
    logic       e_rv8 = 1'b0, e_rv5 = 1'b0;
    logic       e_ovf8 = 1'b0, e_unf8 = 1'b0, e_ovf5 = 1'b0, e_unf5 = 1'b0;

    // One clock of the H=8 FIFO: update the model, drive, advance past the edge.
    task automatic step8(input logic w, input logic [7:0] d, input logic rd, input logic rs);
        bit racc, wacc;
        rst8 = rs; wr8 = w; wd8 = d; r8 = rd;
        if (rs) begin
            q8.delete(); e_rd8 = 8'h00; e_rv8 = 1'b0; e_ovf8 = 1'b0; e_unf8 = 1'b0;
        end else begin
            racc = rd && (q8.size() != 0);
            wacc = w && ((q8.size() < 8) || rd);
            e_rv8 = racc;
            if (racc) e_rd8 = q8.pop_front();
            if (wacc) q8.push_back(d);
            if (w && !wacc) e_ovf8 = ERR_EN;
            if (rd && !racc) e_unf8 = ERR_EN;
        end
        @(posedge clk); #1;
        rst8 = 1'b0; wr8 = 1'b0; r8 = 1'b0;
    endtask

    task automatic step5(input logic w, input logic [7:0] d, input logic rd, input logic rs);
        bit racc, wacc;
        rst5 = rs; wr5 = w; wd5 = d; r5 = rd;
        if (rs) begin
            q5.delete(); e_rd5 = 8'h00; e_rv5 = 1'b0; e_ovf5 = 1'b0; e_unf5 = 1'b0;
        end else begin
            racc = rd && (q5.size() != 0);
            wacc = w && ((q5.size() < 5) || rd);
            e_rv5 = racc;
            if (racc) e_rd5 = q5.pop_front();
            if (wacc) q5.push_back(d);
            if (w && !wacc) e_ovf5 = ERR_EN;
            if (rd && !racc) e_unf5 = ERR_EN;
        end
        @(posedge clk); #1;
        rst5 = 1'b0; wr5 = 1'b0; r5 = 1'b0;
    endtask

    task automatic test_reset();
        fork
            begin step8(1'b1, 8'h3C, 1'b1, 1'b1); step8(1'b0, 8'h00, 1'b0, 1'b1); end
            begin step5(1'b1, 8'h3C, 1'b1, 1'b1); step5(1'b0, 8'h00, 1'b0, 1'b1); end
        join
        tests_run++; if (cnt8 !== 4'd0)    begin tests_failed++; $display("FAIL reset_count8 got %0d want 0", cnt8); end
        tests_run++; if ({empty8, ae8, full8, af8} !== 4'b1100) begin tests_failed++; $display("FAIL reset_flags8 got %b want 1100", {empty8, ae8, full8, af8}); end
        tests_run++; if ({rd8, rv8} !== 9'h000) begin tests_failed++; $display("FAIL reset_rdata8 got %h/%b want 00/0", rd8, rv8); end
        tests_run++; if ({ovf8, unf8} !== 2'b00) begin tests_failed++; $display("FAIL reset_err8 got %b want 00", {ovf8, unf8}); end
        tests_run++; if ({cnt5, empty5, ae5, full5, af5} !== 7'b000_1100) begin tests_failed++; $display("FAIL reset_state5 got %b want 0001100", {cnt5, empty5, ae5, full5, af5}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step8(1'b1, 8'(i), 1'b0, 1'b0);
            tests_run++; if (cnt8 !== 4'(i + 1)) begin tests_failed++; $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt8, i + 1); end
            tests_run++; if ({empty8, ae8, af8, full8} !== {1'b0, (i + 1) <= 2, (i + 1) >= 6, (i + 1) == 8})
                begin tests_failed++; $display("FAIL fill_flags[%0d] got e/ae/af/f=%b", i, {empty8, ae8, af8, full8}); end
        end
    endtask

    task automatic test_overflow();
        step8(1'b1, 8'hAA, 1'b0, 1'b0);
        tests_run++; if ({cnt8, full8} !== {4'd8, 1'b1}) begin tests_failed++; $display("FAIL ovf_count got %0d full %b want 8/1", cnt8, full8); end
        tests_run++; if (ovf8 !== ERR_EN) begin tests_failed++; $display("FAIL ovf_flag got %b want %b", ovf8, ERR_EN); end
        step8(1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++; if (ovf8 !== ERR_EN) begin tests_failed++; $display("FAIL ovf_sticky got %b want %b", ovf8, ERR_EN); end
    endtask

    task automatic test_full_rw();
        step8(1'b1, 8'h55, 1'b1, 1'b0);
        tests_run++; if ({rd8, rv8} !== {8'h00, 1'b1}) begin tests_failed++; $display("FAIL fullrw_data got %h/%b want 00/1", rd8, rv8); end
        tests_run++; if ({cnt8, full8} !== {4'd8, 1'b1}) begin tests_failed++; $display("FAIL fullrw_count got %0d/%b want 8/1", cnt8, full8); end
    endtask

    task automatic test_drain_underflow();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            want = (i < 7) ? 8'(i + 1) : 8'h55;
            step8(1'b0, 8'h00, 1'b1, 1'b0);
            tests_run++; if ({rd8, rv8} !== {want, 1'b1}) begin tests_failed++; $display("FAIL drain_data[%0d] got %h/%b want %h/1", i, rd8, rv8, want); end
            tests_run++; if ({rd8, cnt8, empty8} !== {e_rd8, 4'(q8.size()), i == 7}) begin tests_failed++; $display("FAIL drain_model[%0d] got %h cnt %0d empty %b", i, rd8, cnt8, empty8); end
        end
        step8(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++; if ({unf8, rv8, rd8} !== {ERR_EN, 1'b0, 8'h55}) begin tests_failed++; $display("FAIL underflow got unf %b rv %b rd %h want %b/0/55", unf8, rv8, rd8, ERR_EN); end
    endtask

    task automatic test_wrap_h5();
        int sent = 0, got = 0, cyc = 0;
        bit w, rd;
        step5(1'b0, 8'h00, 1'b0, 1'b1);
        while (got < 20 && cyc < 400) begin
            w  = (sent < 20) && ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 2) != 0);
            if (w && (q5.size() < 5 || (rd && q5.size() != 0))) sent++;
            else w = 1'b0;
            if (rd && q5.size() != 0) got++;
            step5(w, 8'(8'hA0 + sent), rd, 1'b0);
            cyc++;
            if (e_rv5) begin
                tests_run++; if (rd5 !== e_rd5) begin tests_failed++; $display("FAIL wrap_data cyc %0d got %h want %h", cyc, rd5, e_rd5); end
            end
            tests_run++; if ({rv5, cnt5, full5, empty5} !== {e_rv5, 3'(q5.size()), q5.size() == 5, q5.size() == 0})
                begin tests_failed++; $display("FAIL wrap_state cyc %0d got rv %b cnt %0d f/e %b%b", cyc, rv5, cnt5, full5, empty5); end
            tests_run++; if (cnt5 > 3'd5) begin tests_failed++; $display("FAIL wrap_bound got %0d want <=5", cnt5); end
        end
        tests_run++; if (got != 20) begin tests_failed++; $display("FAIL wrap_timeout got %0d items want 20", got); end
    endtask

    task automatic test_reset_midop();
        step8(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step8(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        tests_run++; if (cnt8 !== 4'd4) begin tests_failed++; $display("FAIL midop_fill got %0d want 4", cnt8); end
        step8(1'b1, 8'hEE, 1'b1, 1'b1);
        tests_run++; if ({cnt8, empty8, rd8, rv8, ovf8, unf8} !== {4'd0, 1'b1, 8'h00, 3'b000})
            begin tests_failed++; $display("FAIL midop_reset got cnt %0d e %b rd %h rv %b err %b%b", cnt8, empty8, rd8, rv8, ovf8, unf8); end
        step8(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++; if ({unf8, rv8, cnt8} !== {ERR_EN, 1'b0, 4'd0}) begin tests_failed++; $display("FAIL midop_underflow got unf %b rv %b cnt %0d", unf8, rv8, cnt8); end
        step8(1'b1, 8'h77, 1'b0, 1'b0);
        step8(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++; if ({rd8, rv8, empty8} !== {8'h77, 1'b1, 1'b1}) begin tests_failed++; $display("FAIL midop_fresh got %h/%b/%b want 77/1/1", rd8, rv8, empty8); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_drain_underflow();
        test_wrap_h5();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
